// File: rtl/sram_mem_responder_pkg.sv
// Shared types and constants for the SRAM memory responder.
package sram_mem_responder_pkg;

  localparam int unsigned SRAM_ADDR_W         = 18;
  localparam int unsigned SRAM_DATA_W         = 16;
  localparam int unsigned WIDX_W              = SRAM_ADDR_W - 1;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 3;
  localparam int unsigned DEFAULT_BASE_ADDR   = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_e;

  // SRAM word index of a byte address; upper bits beyond the SRAM are dropped.
  function automatic logic [WIDX_W-1:0] word_index(input logic [31:0] address,
                                                   input logic [31:0] base);
    logic [31:0] offs;
    offs = address - base;
    return WIDX_W'(offs >> 2);
  endfunction

endpackage

// File: rtl/sram_mem_responder_if.sv
// Pipeline-side request/response bundle of the SRAM memory responder.
interface sram_mem_responder_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_mem_responder_half_timer.sv
// Per-half access timer: counts 0..WAIT_CYCLES-1 and flags the final cycle.
module sram_half_timer
  import sram_mem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_run,
  output logic o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(WAIT_CYCLES - 1));
  assign o_last = w_last;

  // Counter wraps after the last cycle so the HI half starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_mem_responder.sv
// 32-bit word access over a 16-bit asynchronous SRAM, low half first.
// Optional last-read buffer enabled by defining SRAM_LAST_READ_BUF_EN.
module sram_mem_responder
  import sram_mem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_mem_responder_if.slave    bus,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  state_e             r_state;
  state_e             w_state_next;
  logic               r_op_wr;
  logic [WIDX_W-1:0]  r_widx;
  logic [31:0]        r_read_data;
  logic [WIDX_W-1:0]  w_widx;
  logic               w_req;
  logic               w_hit;
  logic               w_accept;
  logic               w_busy;
  logic               w_last;
  logic               w_dq_oe;
  logic [SRAM_DATA_W-1:0] w_dq_out;
  logic               w_ready;
  logic [31:0]        w_read_data;

  assign w_widx   = word_index(bus.address, 32'(BASE_ADDR));
  assign w_req    = bus.rd_en | bus.wr_en;
  // Write wins when both requests are present; a buffer hit needs no SRAM access.
  assign w_accept = (r_state == StIdle) && (bus.wr_en || (bus.rd_en && !w_hit));
  assign w_busy   = (r_state == StLo) || (r_state == StHi);

  sram_half_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_accept),
    .i_run  (w_busy),
    .o_last (w_last)
  );

`ifdef SRAM_LAST_READ_BUF_EN
  logic              r_buf_valid;
  logic [WIDX_W-1:0] r_buf_widx;
  logic [31:0]       r_buf_data;

  assign w_hit = (r_state == StIdle) && bus.rd_en && !bus.wr_en && r_buf_valid &&
                 (r_buf_widx == w_widx);

  // Capture each completed read; keep the buffer coherent with writes to its word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_widx  <= '0;
      r_buf_data  <= '0;
    end else if (r_state == StDone) begin
      if (!r_op_wr) begin
        r_buf_valid <= 1'b1;
        r_buf_widx  <= r_widx;
        r_buf_data  <= r_read_data;
      end else if (r_buf_valid && (r_buf_widx == r_widx)) begin
        r_buf_data  <= bus.write_data;
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_next = StLo;
      StLo:    if (w_last)   w_state_next = StHi;
      StHi:    if (w_last)   w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // SRAM strobes, data drive and pipeline handshake outputs.
  always_comb begin
    SRAM_ADDR   = w_busy ? {r_widx, r_state == StHi} : '0;
    SRAM_OE_N   = !(w_busy && !r_op_wr);
    // WE_N rises one cycle before the half ends so data stays valid past the strobe.
    SRAM_WE_N   = !(w_busy && r_op_wr && !w_last);
    SRAM_CE_N   = 1'b0;
    SRAM_UB_N   = 1'b0;
    SRAM_LB_N   = 1'b0;
    w_dq_oe     = w_busy && r_op_wr;
    w_dq_out    = (r_state == StHi) ? bus.write_data[31:16] : bus.write_data[15:0];
    w_ready     = ((r_state == StIdle) && !w_req) || (r_state == StDone) || w_hit;
    w_read_data = r_read_data;
`ifdef SRAM_LAST_READ_BUF_EN
    if (w_hit) w_read_data = r_buf_data;
`endif
  end

  assign SRAM_DQ       = w_dq_oe ? w_dq_out : {SRAM_DATA_W{1'bz}};
  assign bus.ready     = w_ready;
  assign bus.read_data = w_read_data;

  // Latch the operation on acceptance and sample each read half on its last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_wr     <= 1'b0;
      r_widx      <= '0;
      r_read_data <= '0;
    end else begin
      if (w_accept) begin
        r_op_wr <= bus.wr_en;
        r_widx  <= w_widx;
      end
      if (w_busy && !r_op_wr && w_last) begin
        if (r_state == StLo) r_read_data[15:0]  <= SRAM_DQ;
        else                 r_read_data[31:16] <= SRAM_DQ;
      end
`ifdef SRAM_LAST_READ_BUF_EN
      if (w_hit) r_read_data <= r_buf_data;
`endif
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed bench for sram_mem_responder with a behavioural 16-bit SRAM model.
module tb_sram_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
  logic [15:0] mem [64];

  int n_checks = 0;
  int n_fails  = 0;

  sram_mem_responder_if bus_if ();

  sram_mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .SRAM_DQ  (sram_dq),
    .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(sram_we_n),
    .SRAM_OE_N(sram_oe_n),
    .SRAM_CE_N(sram_ce_n),
    .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n)
  );

  always #5 clk = ~clk;

  // Released bus reads as all ones.
  pullup (sram_dq);
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;
  always @(posedge sram_we_n) mem[sram_addr[5:0]] <= sram_dq;

  // Drive one request from cycle 0 and hold it until ready; cycle of first ready returned.
  task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wdata, output int rcyc, output int welow,
                           output logic [31:0] rdata);
    rcyc  = -1;
    welow = 0;
    rdata = '0;
    bus_if.wr_en      = wr;
    bus_if.rd_en      = rd;
    bus_if.address    = addr;
    bus_if.write_data = wdata;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!sram_we_n) welow++;
      if (bus_if.ready) begin
        rcyc  = k;
        rdata = bus_if.read_data;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus_if.ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 ||
          sram_ce_n !== 1'b0 || sram_ub_n !== 1'b0 || sram_lb_n !== 1'b0) begin
        n_fails++;
        $display("FAIL reset_strobes[%0d]: got rdy=%b we=%b oe=%b ce=%b ub=%b lb=%b, want 1 1 1 0 0 0",
                 i, bus_if.ready, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n);
      end
      n_checks++;
      if (sram_addr !== 18'h0 || bus_if.read_data !== 32'h0 || sram_dq !== 16'hffff) begin
        n_fails++;
        $display("FAIL reset_bus[%0d]: got addr=%h rd=%h dq=%h, want 0 0 ffff(released)",
                 i, sram_addr, bus_if.read_data, sram_dq);
      end
      if (i == 0) begin
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write;
    int rc, wl;
    logic [31:0] rd;
    do_access(1'b1, 1'b0, 32'd1024, 32'hdeadbeef, rc, wl, rd);
    n_checks++;
    if (rc != 7) begin
      n_fails++; $display("FAIL write_latency: got %0d, want 7", rc);
    end
    n_checks++;
    if (wl != 4) begin
      n_fails++; $display("FAIL write_we_low_cycles: got %0d, want 4", wl);
    end
    n_checks++;
    if (mem[0] !== 16'hbeef || mem[1] !== 16'hdead) begin
      n_fails++; $display("FAIL write_halves: got %h %h, want beef dead", mem[0], mem[1]);
    end
  endtask

  task automatic test_read;
    int rc, wl;
    logic [31:0] rd;
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, rc, wl, rd);
    n_checks++;
    if (rc != 7 || rd !== 32'hdeadbeef) begin
      n_fails++; $display("FAIL read_back: got cyc=%0d data=%h, want 7 deadbeef", rc, rd);
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.read_data !== 32'hdeadbeef || bus_if.ready !== 1'b1) begin
      n_fails++;
      $display("FAIL read_hold: got %h rdy=%b, want deadbeef 1", bus_if.read_data, bus_if.ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_both_requests;
    int rc, wl;
    logic [31:0] rd;
    do_access(1'b1, 1'b1, 32'd1028, 32'h12345678, rc, wl, rd);
    n_checks++;
    if (rc != 7 || mem[2] !== 16'h5678 || mem[3] !== 16'h1234) begin
      n_fails++;
      $display("FAIL both_write_wins: got cyc=%0d %h %h, want 7 5678 1234", rc, mem[2], mem[3]);
    end
    do_access(1'b0, 1'b1, 32'd1028, 32'h0, rc, wl, rd);
    n_checks++;
    if (rc != 7 || rd !== 32'h12345678) begin
      n_fails++; $display("FAIL both_read_back: got cyc=%0d %h, want 7 12345678", rc, rd);
    end
  endtask

  task automatic test_reset_mid_write;
    int rc, wl;
    logic [31:0] rd;
    bus_if.wr_en      = 1'b1;
    bus_if.address    = 32'd1036;
    bus_if.write_data = 32'hcafef00d;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (sram_dq !== 16'hf00d || sram_addr !== 18'd6) begin
      n_fails++;
      $display("FAIL midwr_driving: got dq=%h addr=%0d, want f00d 6", sram_dq, sram_addr);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq !== 16'hffff ||
        sram_addr !== 18'h0) begin
      n_fails++;
      $display("FAIL midwr_abort: got we=%b oe=%b dq=%h addr=%h, want 1 1 ffff 0",
               sram_we_n, sram_oe_n, sram_dq, sram_addr);
    end
    bus_if.wr_en = 1'b0;
    #1;
    n_checks++;
    if (bus_if.ready !== 1'b1) begin
      n_fails++; $display("FAIL midwr_idle_ready: got %b, want 1", bus_if.ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, rc, wl, rd);
    n_checks++;
    if (rc != 7 || rd !== 32'hdeadbeef) begin
      n_fails++; $display("FAIL midwr_next_read: got cyc=%0d %h, want 7 deadbeef", rc, rd);
    end
  endtask

  task automatic test_repeat_read;
    int rc, wl;
    logic [31:0] rd;
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, rc, wl, rd);
`ifdef SRAM_LAST_READ_BUF_EN
    n_checks++;
    if (rc != 0 || rd !== 32'hdeadbeef) begin
      n_fails++; $display("FAIL buf_hit: got cyc=%0d %h, want 0 deadbeef", rc, rd);
    end
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, rc, wl, rd);
    n_checks++;
    if (rc != 7 || mem[0] !== 16'h0 || mem[1] !== 16'h0) begin
      n_fails++;
      $display("FAIL buf_write: got cyc=%0d %h %h, want 7 0000 0000", rc, mem[0], mem[1]);
    end
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, rc, wl, rd);
    n_checks++;
    if (rc != 0 || rd !== 32'h0) begin
      n_fails++; $display("FAIL buf_updated: got cyc=%0d %h, want 0 00000000", rc, rd);
    end
`else
    n_checks++;
    if (rc != 7 || rd !== 32'hdeadbeef) begin
      n_fails++; $display("FAIL repeat_read: got cyc=%0d %h, want 7 deadbeef", rc, rd);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    bus_if.rd_en      = 1'b0;
    bus_if.wr_en      = 1'b0;
    bus_if.address    = 32'h0;
    bus_if.write_data = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_write();
    test_read();
    test_both_requests();
    test_reset_mid_write();
    test_repeat_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
